// File: rtl/pc_ctrl.sv
// Program counter controller: sequences fetch addresses through IDLE/RUN/FLUSH/HALTED,
// handles branch redirects with a fixed flush window, and counts stalls and redirects.
module pc_ctrl #(
    parameter int unsigned PC_W         = 7,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] pc,
    output logic            if_valid,
    output logic            flush,
    output logic [1:0]      state,
    output logic [7:0]      stall_cnt,
    output logic [7:0]      redirect_cnt
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFlush  = 2'd2,
        StHalted = 2'd3
    } state_e;

    // Counter reload value; the first flush cycle is the one that loads it.
    localparam logic [3:0]      FlushLoad = 4'(FLUSH_CYCLES - 1);
    localparam logic [PC_W-1:0] ResetPc   = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PcOne     = PC_W'(1);

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [3:0]      fcnt_q;
    logic [7:0]      stall_cnt_q;
    logic [7:0]      redirect_cnt_q;

    // Single FSM: rst beats redirect, which beats halt, which beats stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            pc_q           <= ResetPc;
            fcnt_q         <= 4'd0;
            stall_cnt_q    <= 8'd0;
            redirect_cnt_q <= 8'd0;
        end else if (redirect) begin
            // Accepted in every state, including mid-flush (reloads the window).
            state_q <= StFlush;
            pc_q    <= redirect_pc;
            fcnt_q  <= FlushLoad;
            if (redirect_cnt_q != 8'hff) begin
                redirect_cnt_q <= redirect_cnt_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    // One dead cycle with pc held before fetch starts.
                    state_q <= halt ? StHalted : StRun;
                end
                StRun: begin
                    if (halt) begin
                        state_q <= StHalted;
                    end else if (stall) begin
                        if (stall_cnt_q != 8'hff) begin
                            stall_cnt_q <= stall_cnt_q + 8'd1;
                        end
                    end else begin
                        pc_q <= pc_q + PcOne;
                    end
                end
                StFlush: begin
                    // Stall is ignored; halt only takes effect once the window closes.
                    if (fcnt_q != 4'd0) begin
                        pc_q   <= pc_q + PcOne;
                        fcnt_q <= fcnt_q - 4'd1;
                    end else if (halt) begin
                        state_q <= StHalted;
                    end else begin
                        pc_q    <= pc_q + PcOne;
                        state_q <= StRun;
                    end
                end
                StHalted: begin
                    // Resume holds pc for the first RUN cycle.
                    if (!halt) begin
                        state_q <= StRun;
                    end
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign state        = state_q;
    assign if_valid     = (state_q == StRun) || (state_q == StFlush);
    assign flush        = (state_q == StFlush);
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: stimulus pushes model predictions, a monitor pops and compares.
module tb_pc_ctrl;

    localparam int PC_W = 7;
    localparam int NPC  = 1 << PC_W;
    localparam int FC   = 2;

    logic            clk;
    logic            rst;
    logic            halt;
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] pc;
    logic            if_valid;
    logic            flush;
    logic [1:0]      state;
    logic [7:0]      stall_cnt;
    logic [7:0]      redirect_cnt;

    pc_ctrl #(
        .PC_W        (PC_W),
        .RESET_PC    (0),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .if_valid    (if_valid),
        .flush       (flush),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .redirect_cnt(redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int st;
        int iv;
        int fl;
        int sc;
        int rc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    // Reference model: 0=IDLE 1=RUN 2=FLUSH 3=HALTED, flush cycles left in m_left.
    int m_pc = 0;
    int m_st = 0;
    int m_left = 0;
    int m_sc = 0;
    int m_rc = 0;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_step(input bit r, input bit h, input bit s, input bit rd,
                              input int rpc);
        if (r) begin
            m_pc = 0; m_st = 0; m_left = 0; m_sc = 0; m_rc = 0;
        end else if (rd) begin
            m_pc = rpc; m_st = 2; m_left = FC - 1; m_rc = sat(m_rc + 1);
        end else if (m_st == 0) begin
            m_st = h ? 3 : 1;
        end else if (m_st == 1) begin
            if (h) m_st = 3;
            else if (s) m_sc = sat(m_sc + 1);
            else m_pc = (m_pc + 1) % NPC;
        end else if (m_st == 2) begin
            if (m_left > 0) begin
                m_pc = (m_pc + 1) % NPC; m_left = m_left - 1;
            end else if (h) begin
                m_st = 3;
            end else begin
                m_pc = (m_pc + 1) % NPC; m_st = 1;
            end
        end else begin
            if (!h) m_st = 1;
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, advance past the edge.
    task automatic cyc(input bit r, input bit h, input bit s, input bit rd, input int rpc);
        exp_t e;
        rst = r; halt = h; stall = s; redirect = rd; redirect_pc = PC_W'(rpc);
        model_step(r, h, s, rd, rpc);
        e.pc = m_pc; e.st = m_st;
        e.iv = (m_st == 1 || m_st == 2) ? 1 : 0;
        e.fl = (m_st == 2) ? 1 : 0;
        e.sc = m_sc; e.rc = m_rc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            failures = failures + 1;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare after each edge settles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", int'(pc), e.pc);
                chk("state", int'(state), e.st);
                chk("if_valid", int'(if_valid), e.iv);
                chk("flush", int'(flush), e.fl);
                chk("stall_cnt", int'(stall_cnt), e.sc);
                chk("redirect_cnt", int'(redirect_cnt), e.rc);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        // Reset for two cycles, then idle and free run.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        // Land in RUN at pc=5, then stall three cycles.
        cyc(0, 0, 0, 1, 3);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        // Redirect to 40 with stall asserted during the flush window.
        cyc(0, 0, 0, 1, 40);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Halt and redirect together, hold halt, then release.
        cyc(0, 1, 0, 1, 20);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        // Wrap 127 -> 0.
        cyc(0, 0, 0, 1, 124);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
        // Reset during the first flush cycle.
        cyc(0, 0, 0, 1, 40);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Saturate both counters.
        for (int i = 0; i < 300; i++) cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 0, 0, 1, $urandom_range(0, NPC - 1));
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);
        // Randomized mix with rare resets.
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 999);
            cyc((r < 5) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                $urandom_range(0, NPC - 1));
        end
        cyc(0, 0, 0, 0, 0);
        stim_done = 1'b1;
        @(posedge clk);
        #5;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: actual=%0d required=0 pending", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 7, program counter width in bits (word index).
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, range 1-15, number of flush cycles after a redirect.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port halt  input  1  level request to freeze fetch.
REQ-007 SHALL have port stall  input  1  load-use hazard; holds the PC for each cycle it is high.
REQ-008 SHALL have port redirect  input  1  taken branch or jump from EX.
REQ-009 SHALL have port redirect_pc  input  PC_W  redirect target.
REQ-010 SHALL have port pc  output  PC_W  current fetch address, registered.
REQ-011 SHALL have port if_valid  output  1  pc is a live fetch address.
REQ-012 SHALL have port flush  output  1  kill the IF/ID and ID/EX contents.
REQ-013 SHALL have port state  output  2  FSM state: IDLE=0, RUN=1, FLUSH=2, HALTED=3.
REQ-014 SHALL have port stall_cnt  output  8  count of stalled RUN cycles, saturating at 255.
REQ-015 SHALL have port redirect_cnt  output  8  count of accepted redirects, saturating at 255.

Function
REQ-016 SHALL evaluate inputs in fixed priority: rst > redirect > halt > stall > increment.
REQ-017 SHALL drive if_valid=1 only in RUN and FLUSH, and flush=1 only in FLUSH; both SHALL be decoded from the registered state.
REQ-018 IDLE: SHALL hold pc for exactly one cycle, then go to HALTED if halt=1 (or FLUSH if redirect=1), else go to RUN.
REQ-019 RUN, redirect=1: SHALL load pc<=redirect_pc, enter FLUSH, load flush counter with FLUSH_CYCLES-1, and increment redirect_cnt.
REQ-020 RUN, halt=1: SHALL hold pc and enter HALTED.
REQ-021 RUN, stall=1: SHALL hold pc, stay in RUN, and increment stall_cnt.
REQ-022 RUN, no event: SHALL set pc<=pc+1 modulo 2^PC_W, wrapping 127->0 when PC_W=7.
REQ-023 FLUSH: SHALL ignore stall and SHALL NOT count it.
REQ-024 FLUSH, redirect=1: SHALL reload pc and the flush counter, re-enter FLUSH, and increment redirect_cnt.
REQ-025 FLUSH, counter!=0: SHALL set pc<=pc+1 and decrement the counter.
REQ-026 FLUSH, counter==0, halt=0: SHALL set pc<=pc+1 and enter RUN.
REQ-027 FLUSH, counter==0, halt=1: SHALL hold pc and enter HALTED.
REQ-028 HALTED: SHALL hold pc and ignore stall.
REQ-029 HALTED, redirect=1: SHALL behave as REQ-019.
REQ-030 HALTED, halt=0 with no redirect: SHALL go to RUN and hold pc for that cycle.
REQ-031 Both counters SHALL hold at 255 and never wrap; they SHALL be cleared only by rst.
REQ-032 redirect_pc SHALL be taken unmodified, with no alignment or range check.

Reset
REQ-033 While rst=1 at a clock edge: pc=RESET_PC, state=IDLE, flush counter=0, stall_cnt=0, redirect_cnt=0; if_valid and flush SHALL therefore read 0.
REQ-034 rst SHALL override every other input in every state, including mid-FLUSH and HALTED.
REQ-035 The first cycle after rst falls SHALL be IDLE.

Verification (FLUSH_CYCLES=2, PC_W=7)
REQ-036 Reset: rst=1 for 2 cycles, then released -> pc=0, state=IDLE, if_valid=0, flush=0; next cycle RUN with pc=0; then pc=1, 2, 3 on successive cycles.
REQ-037 Wrap: free run from pc=126 -> pc=127, then pc=0; if_valid stays 1.
REQ-038 Stall: at pc=5, stall=1 for 3 cycles -> pc=5 for 3 cycles, stall_cnt=3, then pc=6.
REQ-039 Redirect: at pc=10, redirect=1 with redirect_pc=40 for one cycle -> pc=40 (FLUSH, flush=1), pc=41 (FLUSH, flush=1), then pc=42 (RUN, flush=0); redirect_cnt=1; a stall during FLUSH leaves stall_cnt unchanged.
REQ-040 Simultaneous events: halt=1 held and redirect=1 with redirect_pc=20 in the same cycle -> pc=20 (FLUSH), pc=21 (FLUSH), then pc=21 (HALTED) and held; after halt=0 -> pc=21 (RUN), then 22.
REQ-041 Reset mid-operation: rst=1 during the first FLUSH cycle at pc=40 -> pc=0, state=IDLE, flush=0, both counters 0.
